// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the 5-stage core.
//
// It resolves four hazard sources with a fixed priority: taken branch, then
// multi-cycle mul/div, then load-use, then instruction-fetch wait. From that it
// drives the PC, IF/ID and ID/EX pipeline-register controls. It also keeps a
// saturating count of the cycles in which the PC did not advance.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   id_rs1/id_rs2        source registers of the ID instruction
//   id_uses_rs1/rs2      ID instruction actually reads that source
//   ex_valid             EX holds a real instruction (not a bubble)
//   ex_rd                EX destination register
//   ex_mem_read          EX instruction is a load
//   ex_muldiv            EX instruction is a multi-cycle mul/div
//   branch_taken         EX redirects the PC this cycle
//   imem_ready           fetch data is valid this cycle
//   pc_write             PC load enable
//   if_id_write/stall/flush  IF/ID load, hold and clear controls
//   id_ex_bubble/hold    ID/EX inject-NOP and hold controls
//   busy                 registered: controller is waiting on a mul/div
//   stall_cycles         registered saturating count of pc_write=0 cycles
module hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_muldiv,
    input  logic              branch_taken,
    input  logic              imem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              id_ex_hold,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [0:0] {StRun, StMulWait} state_e;

    // The entry cycle in RUN already counts as one stall cycle, and MUL_WAIT
    // runs for cnt+1 cycles, so loading MUL_LAT-2 gives MUL_LAT stalls in total.
    localparam logic [3:0] MulInit = 4'(MUL_LAT - 2);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               busy_q;
    logic               load_use;

    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (rst) begin
            // Keep the pipeline full of bubbles while in reset.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = StRun;
            cnt_d        = '0;
        end else begin
            case (state_q)
                StMulWait: begin
                    // EX is frozen, so branch, load-use and fetch are ignored.
                    if_id_stall = 1'b1;
                    id_ex_hold  = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    if (branch_taken) begin
                        pc_write     = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (ex_valid && ex_muldiv) begin
                        if_id_stall = 1'b1;
                        id_ex_hold  = 1'b1;
                        state_d     = StMulWait;
                        cnt_d       = MulInit;
                    end else if (load_use) begin
                        // Single-cycle stall: the bubble removes the hazard.
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (!imem_ready) begin
                        // Let downstream drain; feed a bubble into ID.
                        if_id_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
            stall_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            busy_q  <= (state_d == StMulWait);
        end
    end

    assign busy         = busy_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed steps then randomized cycles,
// compared against a behavioural model that tracks remaining mul/div stall
// cycles and a plain integer stall count saturated per counter width.
module tb_hazard_ctrl;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MUL_LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read, ex_muldiv;
    logic              branch_taken, imem_ready;

    logic              pc_write, if_id_write, if_id_stall, if_id_flush;
    logic              id_ex_bubble, id_ex_hold, busy;
    logic [31:0]       stall_cycles;
    logic              s_pc_write, s_if_id_write, s_if_id_stall, s_if_id_flush;
    logic              s_id_ex_bubble, s_id_ex_hold, s_busy;
    logic [3:0]        s_stall_cycles;

    int checks = 0;
    int errors = 0;

    // Model state
    int     rem_stall;   // remaining frozen cycles after a mul/div entry
    longint stall_cnt;   // unbounded count of pc_write=0 cycles since reset
    bit     known;       // DUT registers have seen a reset edge
    logic [5:0] exp_ctrl;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .busy(busy),
        .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .pc_write(s_pc_write),
        .if_id_write(s_if_id_write), .if_id_stall(s_if_id_stall),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble),
        .id_ex_hold(s_id_ex_hold), .busy(s_busy), .stall_cycles(s_stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {pc_write, if_id_write, if_id_stall, if_id_flush, id_ex_bubble, id_ex_hold}
    function automatic logic [5:0] model_ctrl();
        bit lu;
        lu = ex_valid && ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (rst)                       return 6'b000110;
        if (rem_stall > 0)             return 6'b001001;
        if (branch_taken)              return 6'b100110;
        if (ex_valid && ex_muldiv)     return 6'b001001;
        if (lu)                        return 6'b001010;
        if (!imem_ready)               return 6'b000100;
        return 6'b110000;
    endfunction

    function automatic logic [31:0] sat(input longint v, input longint max);
        return (v > max) ? 32'(max) : 32'(v);
    endfunction

    task automatic idle();
        rst = 1'b0; branch_taken = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
        ex_muldiv = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; imem_ready = 1'b1;
    endtask

    // Check one cycle's outputs against the model, then clock and advance it.
    task automatic step(input string tag);
        #1;
        exp_ctrl = model_ctrl();
        check({tag, ".ctrl"}, {26'd0, pc_write, if_id_write, if_id_stall, if_id_flush,
                               id_ex_bubble, id_ex_hold}, {26'd0, exp_ctrl});
        check({tag, ".ctrl_sat"}, {26'd0, s_pc_write, s_if_id_write, s_if_id_stall,
                                   s_if_id_flush, s_id_ex_bubble, s_id_ex_hold},
              {26'd0, exp_ctrl});
        if (known) begin
            check({tag, ".busy"}, {31'd0, busy}, {31'd0, rem_stall > 0});
            check({tag, ".stall32"}, stall_cycles, sat(stall_cnt, 64'hFFFF_FFFF));
            check({tag, ".stall4"}, {28'd0, s_stall_cycles}, sat(stall_cnt, 15));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            rem_stall = 0;
            stall_cnt = 0;
            known     = 1'b1;
        end else begin
            if (!exp_ctrl[5]) stall_cnt++;
            if (rem_stall > 0) rem_stall--;
            else if (!branch_taken && ex_valid && ex_muldiv) rem_stall = MUL_LAT - 1;
        end
    endtask

    initial begin
        rem_stall = 0;
        stall_cnt = 0;
        known     = 1'b0;
        idle();

        // Reset with a branch asserted: outputs forced, counter cleared.
        rst = 1'b1; branch_taken = 1'b1;
        step("reset0");
        step("reset1");
        check("reset.stall_cycles", stall_cycles, 32'd0);
        idle();
        step("run_free");

        // Load-use on rs2, then the bubble cycle proceeds.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        #1;
        check("loaduse.stall", {31'd0, if_id_stall}, 32'd1);
        step("loaduse");
        ex_valid = 1'b0;
        step("loaduse_after");
        ex_valid = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        step("loaduse_x0");

        // Mul/div: four stall cycles, branch pulse inside the wait is ignored.
        idle();
        ex_valid = 1'b1; ex_muldiv = 1'b1;
        step("mul_entry");
        idle();
        ex_valid = 1'b1; ex_muldiv = 1'b1;  // EX frozen, still holds the mul
        step("mul_wait1");
        branch_taken = 1'b1;
        #1;
        check("mul_wait.flush_ignored", {31'd0, if_id_flush}, 32'd0);
        step("mul_wait2");
        branch_taken = 1'b0;
        step("mul_wait3");
        idle();
        check("mul.stall_total", stall_cycles, 32'd5);
        step("mul_exit");

        // Branch outranks both mul/div and load-use.
        branch_taken = 1'b1; ex_valid = 1'b1; ex_muldiv = 1'b1; ex_mem_read = 1'b1;
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
        step("branch_prio");
        idle();
        step("branch_after");

        // Fetch wait for three cycles, then overlapping a load-use.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("fetch_wait");
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        step("fetch_loaduse");

        // Reset while in MUL_WAIT.
        idle();
        ex_valid = 1'b1; ex_muldiv = 1'b1;
        step("rst_mul_entry");
        step("rst_mul_wait");
        rst = 1'b1;
        step("rst_mul_reset");
        idle();
        check("rst_mul.busy", {31'd0, busy}, 32'd0);
        step("rst_mul_after");

        // Drive the 4-bit counter into saturation.
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) step("saturate");
        check("saturate.stall4", {28'd0, s_stall_cycles}, 32'd15);
        idle();

        // Randomized traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 99) < 2);
            branch_taken = ($urandom_range(0, 99) < 15);
            ex_valid     = ($urandom_range(0, 99) < 70);
            ex_mem_read  = ($urandom_range(0, 99) < 40);
            ex_muldiv    = ($urandom_range(0, 99) < 8);
            ex_rd        = REG_AW'($urandom_range(0, 3));
            id_rs1       = REG_AW'($urandom_range(0, 3));
            id_rs2       = REG_AW'($urandom_range(0, 3));
            id_uses_rs1  = $urandom_range(0, 1) == 1;
            id_uses_rs2  = $urandom_range(0, 1) == 1;
            imem_ready   = ($urandom_range(0, 99) < 80);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It drives the write, stall and flush controls of the IF/ID register, the PC write enable, and the ID/EX bubble and hold controls. It resolves four hazard sources under one priority scheme: taken branches, multi-cycle mul/div ops, load-use dependences and instruction-fetch wait. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_AW, 5, register address width
- MUL_LAT, 4, total front-end stall cycles per mul/div op (legal range 2..15)
- CNT_W, 32, width of the stall performance counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1 / rs2
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_rd  in  REG_AW  EX destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_muldiv  in  1  EX instruction is a multi-cycle mul/div
- branch_taken  in  1  EX resolved a taken branch or jump (redirect this cycle)
- imem_ready  in  1  fetch data valid this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID load enable
- if_id_stall  out  1  IF/ID hold
- if_id_flush  out  1  IF/ID clear to zero (bubble)
- id_ex_bubble  out  1  ID/EX loads a NOP
- id_ex_hold  out  1  ID/EX holds its contents
- busy  out  1  FSM in MUL_WAIT
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

## Operation
- Registered FSM states: RUN, MUL_WAIT. State lives in a 4-bit down-counter cnt.
- All control outputs are combinational from current state plus inputs. stall_cycles and busy are registered.
- The outputs are mutually consistent:
  - if_id_write=1 implies if_id_stall=0 and if_id_flush=0.
  - At most one of if_id_stall and if_id_flush is 1.

Output rules in RUN, highest priority first:
1. branch_taken=1:
   - pc_write=1, if_id_flush=1, id_ex_bubble=1.
   - Everything else 0. Stay in RUN even if ex_muldiv=1.
2. ex_valid & ex_muldiv:
   - pc_write=0, if_id_stall=1, id_ex_hold=1.
   - Next state MUL_WAIT with cnt=MUL_LAT-2.
3. Load-use: ex_valid & ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)):
   - pc_write=0, if_id_stall=1, id_ex_bubble=1.
   - Lasts one cycle only; the bubble clears the hazard, so no state is needed.
4. imem_ready=0:
   - pc_write=0, if_id_flush=1 (bubble into ID), id_ex_bubble=0.
   - Downstream keeps draining.
5. Otherwise: pc_write=1, if_id_write=1, all others 0.

MUL_WAIT:
- Outputs: pc_write=0, if_id_stall=1, id_ex_hold=1, everything else 0.
- branch_taken, load-use and imem_ready are ignored, because EX is frozen.
- If cnt==0, next state is RUN; otherwise cnt decrements.
- busy=1 while in MUL_WAIT.

Performance counter:
- stall_cycles increments on every non-reset cycle with pc_write=0.
- It saturates at all-ones and does not wrap.

## Timing
- Reset (rst=1 at a clock edge): state=RUN, cnt=0, busy=0, stall_cycles=0.
- While rst=1, outputs are forced regardless of inputs:
  - pc_write=0, if_id_write=0, if_id_stall=0, if_id_flush=1, id_ex_bubble=1, id_ex_hold=0.
- Reset during MUL_WAIT aborts the wait and returns to RUN on the next edge.
- Mul/div stall length: exactly MUL_LAT consecutive cycles with pc_write=0. That is the entry cycle in RUN plus MUL_LAT-1 cycles in MUL_WAIT. The first cycle back in RUN evaluates the normal rules.
- Load-use stall: exactly 1 cycle. The following cycle proceeds when ex_valid=0 (the bubble).
- Control outputs have zero latency: they respond in the same cycle as their inputs.
- Simultaneous events:
  - branch + load-use: flush wins, no stall.
  - muldiv + load-use: hold wins, and the load-use hazard is re-evaluated after exit.
  - load-use + imem_ready=0: stall wins, and IF/ID is held, not flushed.
- ex_rd=0 never triggers a load-use stall.

## Test plan
- Reset: rst=1 for 2 cycles with branch_taken=1 → if_id_flush=1, pc_write=0, stall_cycles=0. After release with no hazards → pc_write=1, if_id_write=1.
- Load-use: ex_valid=1, ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle of if_id_stall=1, id_ex_bubble=1, pc_write=0. Repeat with ex_rd=0 → no stall.
- Mul/div with MUL_LAT=4: one cycle ex_muldiv=1 → pc_write=0 for exactly 4 cycles, busy=1 for the last 3, stall_cycles=4. A branch_taken pulse inside MUL_WAIT is ignored (if_id_flush stays 0).
- Branch priority: branch_taken=1 with load-use and ex_muldiv both asserted → pc_write=1, if_id_flush=1, id_ex_bubble=1; next state RUN, busy=0.
- Fetch wait: imem_ready=0 for 3 cycles → if_id_flush=1, pc_write=0 each cycle, stall_cycles +3. Overlap with load-use → if_id_stall=1, if_id_flush=0.
- Saturation and reset mid-operation:
  - Preload near saturation by running with CNT_W=4 and 20 stall cycles → stall_cycles=15.
  - rst asserted in MUL_WAIT → next cycle state RUN, busy=0, counter 0.
